// File: rtl/tlb_ctrl.sv
// tlb_ctrl: 16-entry TLB storage and CP0 TLB instruction sequencer
// (TLBP / TLBR / TLBWI / TLBWR) with the CP0 Random register.
// Optional feature: define TLB_FLUSH_EN to add the flush input, which
// clears the valid bits of every entry while the block is idle.

package tlb_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module tlb_ctrl (
  input  logic                        clk,
  input  logic                        rst,
`ifdef TLB_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [1:0]                  op,
  input  logic [3:0]                  index_in,
  input  logic [31:0]                 entryhi_in,
  input  logic [31:0]                 entrylo0_in,
  input  logic [31:0]                 entrylo1_in,
  input  logic [3:0]                  wired_in,
  input  logic                        wired_we,
  output logic                        resp_valid,
  output logic [31:0]                 index_out,
  output logic [31:0]                 entryhi_out,
  output logic [31:0]                 entrylo0_out,
  output logic [31:0]                 entrylo1_out,
  output logic [3:0]                  random_out,
  output tlb_pkg::tlb_entry_t [15:0]  entries
);
  import tlb_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {OP_TLBP = 2'b00, OP_TLBR = 2'b01,
                            OP_TLBWI = 2'b10, OP_TLBWR = 2'b11} op_t;

  state_t                 state;
  tlb_entry_t [15:0]      tlb_q;
  op_t                    op_q;
  logic [3:0]             idx_q;
  logic [3:0]             rnd_q;
  logic [18:0]            vpn2_q;
  logic [7:0]             asid_q;
  logic [25:0]            lo0_q;
  logic [25:0]            lo1_q;
  logic                   flush_act;
  logic                   hit;
  logic [3:0]             hit_idx;
  logic [3:0]             wr_idx;
  tlb_entry_t             wr_entry;
  tlb_entry_t             rd_entry;
  logic                   unused_bits;

  // Operand bits that no TLB field maps to.
  assign unused_bits = ^{entryhi_in[12:8], entrylo0_in[31:26], entrylo1_in[31:26]};

`ifdef TLB_FLUSH_EN
  assign flush_act = flush && (state == S_IDLE);
`else
  assign flush_act = 1'b0;
`endif

  assign op_ready = (state == S_IDLE) && !flush_act;
  assign entries  = tlb_q;

  // Random register: free-running down-counter wrapping above Wired.
  always_ff @(posedge clk) begin
    if (rst || wired_we)
      random_out <= 4'd15;
    else if (random_out <= wired_in)
      random_out <= 4'd15;
    else
      random_out <= random_out - 4'd1;
  end

  // Probe: lowest-numbered entry matching the latched EntryHi.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!hit && tlb_q[i].vpn2 == vpn2_q &&
          (tlb_q[i].asid == asid_q || tlb_q[i].g)) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  // Entry image for writes, write target and read source.
  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = vpn2_q;
    wr_entry.asid = asid_q;
    wr_entry.g    = lo0_q[0] & lo1_q[0];
    wr_entry.pfn0 = lo0_q[25:6];
    wr_entry.c0   = lo0_q[5:3];
    wr_entry.d0   = lo0_q[2];
    wr_entry.v0   = lo0_q[1];
    wr_entry.pfn1 = lo1_q[25:6];
    wr_entry.c1   = lo1_q[5:3];
    wr_entry.d1   = lo1_q[2];
    wr_entry.v1   = lo1_q[1];
    wr_idx        = (op_q == OP_TLBWR) ? rnd_q : idx_q;
    rd_entry      = tlb_q[idx_q];
  end

  // Sequencer FSM with registered results and TLB array storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      resp_valid   <= 1'b0;
      index_out    <= '0;
      entryhi_out  <= '0;
      entrylo0_out <= '0;
      entrylo1_out <= '0;
      tlb_q        <= '0;
      op_q         <= OP_TLBP;
      idx_q        <= '0;
      rnd_q        <= '0;
      vpn2_q       <= '0;
      asid_q       <= '0;
      lo0_q        <= '0;
      lo1_q        <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_act) begin
            for (int unsigned i = 0; i < 16; i++) begin
              tlb_q[i].v0 <= 1'b0;
              tlb_q[i].v1 <= 1'b0;
            end
          end else if (op_valid) begin
            op_q   <= op_t'(op);
            idx_q  <= index_in;
            rnd_q  <= random_out;
            vpn2_q <= entryhi_in[31:13];
            asid_q <= entryhi_in[7:0];
            lo0_q  <= entrylo0_in[25:0];
            lo1_q  <= entrylo1_in[25:0];
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          case (op_q)
            OP_TLBP:
              index_out <= hit ? {28'b0, hit_idx} : 32'h8000_0000;
            OP_TLBR: begin
              entryhi_out  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
              entrylo0_out <= {6'b0, rd_entry.pfn0, rd_entry.c0,
                               rd_entry.d0, rd_entry.v0, rd_entry.g};
              entrylo1_out <= {6'b0, rd_entry.pfn1, rd_entry.c1,
                               rd_entry.d1, rd_entry.v1, rd_entry.g};
            end
            default:
              tlb_q[wr_idx] <= wr_entry;
          endcase
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed self-checking bench for tlb_ctrl.
module tb_tlb_ctrl;
  logic                       clk = 1'b0;
  logic                       rst;
`ifdef TLB_FLUSH_EN
  logic                       flush;
`endif
  logic                       op_valid;
  logic                       op_ready;
  logic [1:0]                 op;
  logic [3:0]                 index_in;
  logic [31:0]                entryhi_in, entrylo0_in, entrylo1_in;
  logic [3:0]                 wired_in;
  logic                       wired_we;
  logic                       resp_valid;
  logic [31:0]                index_out, entryhi_out, entrylo0_out, entrylo1_out;
  logic [3:0]                 random_out;
  tlb_pkg::tlb_entry_t [15:0] entries;

  int checks = 0;
  int errors = 0;
  localparam tlb_pkg::tlb_entry_t ZERO_ENTRY = '0;

  tlb_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef TLB_FLUSH_EN
    .flush(flush),
`endif
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .index_in(index_in),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
    .wired_in(wired_in), .wired_we(wired_we), .resp_valid(resp_valid),
    .index_out(index_out), .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out),
    .entrylo1_out(entrylo1_out), .random_out(random_out), .entries(entries)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check the accept-to-response latency and pulse width.
  task automatic do_op(input logic [1:0] o, input logic [3:0] idx,
                       input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input string name);
    int cyc;
    op = o; index_in = idx; entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready got %b want 1", name, op_ready);
    end
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 6) begin
      step();
      cyc++;
    end
    checks++;
    if (resp_valid !== 1'b1 || cyc != 2) begin
      errors++; $display("FAIL %s_latency got %0d want 2", name, cyc);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_pulse got %b want 0", name, resp_valid);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rnd;
    rst = 1'b1; wired_in = 4'd3;
    step(); step();
    checks++;
    if (random_out !== 4'd15 || resp_valid !== 1'b0 || index_out !== 32'h0 ||
        entryhi_out !== 32'h0 || entrylo0_out !== 32'h0 || entrylo1_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got rnd=%0d resp=%b idx=%h hi=%h want 15 0 0 0",
               random_out, resp_valid, index_out, entryhi_out);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (entries[i] !== ZERO_ENTRY) begin
        errors++; $display("FAIL reset_entry%0d got %h want 0", i, entries[i]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", op_ready);
    end
    exp_rnd = 4'd15;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_rnd = (exp_rnd <= 4'd3) ? 4'd15 : exp_rnd - 4'd1;
      checks++;
      if (random_out !== exp_rnd) begin
        errors++; $display("FAIL random_seq%0d got %0d want %0d", i, random_out, exp_rnd);
      end
    end
    wired_in = 4'd0;
  endtask

  task automatic test_tlbwi();
    // lo0: PFN=0xABC, V=1, G=1; lo1: G=0 -> entry G=0
    do_op(2'b10, 4'd5, 32'h1234_A02A, 32'h0002_AF03, 32'h0, "wi5");
    checks++;
    if (entries[5].vpn2 !== 19'h091A5 || entries[5].asid !== 8'h2A || entries[5].g !== 1'b0 ||
        entries[5].pfn0 !== 20'h00ABC || entries[5].v0 !== 1'b1 || entries[5].v1 !== 1'b0) begin
      errors++; $display("FAIL wi5_entry got %h", entries[5]);
    end
    checks++;
    if (index_out !== 32'h0 || entryhi_out !== 32'h0) begin
      errors++; $display("FAIL wi5_outs_held got idx=%h hi=%h want 0 0", index_out, entryhi_out);
    end
  endtask

  task automatic test_tlbp();
    do_op(2'b10, 4'd2, 32'h8000_2011, 32'h1, 32'h1, "wi2");
    do_op(2'b10, 4'd9, 32'h8000_2011, 32'h1, 32'h1, "wi9");
    do_op(2'b00, 4'd0, 32'h8000_20FF, 32'h0, 32'h0, "p_global");
    checks++;
    if (index_out !== 32'h0000_0002) begin
      errors++; $display("FAIL p_global got %h want 00000002", index_out);
    end
    do_op(2'b00, 4'd0, 32'h0000_4000, 32'h0, 32'h0, "p_miss");
    checks++;
    if (index_out !== 32'h8000_0000) begin
      errors++; $display("FAIL p_miss got %h want 80000000", index_out);
    end
    do_op(2'b00, 4'd0, 32'h1234_A02B, 32'h0, 32'h0, "p_asid");
    checks++;
    if (index_out !== 32'h8000_0000) begin
      errors++; $display("FAIL p_asid got %h want 80000000", index_out);
    end
    do_op(2'b00, 4'd0, 32'h1234_A02A, 32'h0, 32'h0, "p_hit5");
    checks++;
    if (index_out !== 32'h0000_0005 || entryhi_out !== 32'h0) begin
      errors++; $display("FAIL p_hit5 got idx=%h hi=%h want 00000005 0", index_out, entryhi_out);
    end
  endtask

  task automatic test_tlbr();
    do_op(2'b01, 4'd5, 32'hFFFF_FFFF, 32'h0, 32'h0, "r5");
    checks++;
    if (entryhi_out !== 32'h1234_A02A || entrylo0_out !== 32'h0002_AF02 ||
        entrylo1_out !== 32'h0) begin
      errors++;
      $display("FAIL r5 got hi=%h lo0=%h lo1=%h want 1234a02a 0002af02 0",
               entryhi_out, entrylo0_out, entrylo1_out);
    end
    checks++;
    if (index_out !== 32'h0000_0005) begin
      errors++; $display("FAIL r5_index_held got %h want 00000005", index_out);
    end
    do_op(2'b01, 4'd2, 32'h0, 32'h0, 32'h0, "r2");
    checks++;
    if (entryhi_out !== 32'h8000_2011 || entrylo0_out !== 32'h1 || entrylo1_out !== 32'h1) begin
      errors++;
      $display("FAIL r2 got hi=%h lo0=%h lo1=%h want 80002011 1 1",
               entryhi_out, entrylo0_out, entrylo1_out);
    end
  endtask

  task automatic test_random_wired();
    int n;
    n = 0;
    while (random_out !== 4'd7 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (random_out !== 4'd7) begin
      errors++; $display("FAIL wait_rnd7 got %0d want 7", random_out);
    end
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    checks++;
    if (random_out !== 4'd15) begin
      errors++; $display("FAIL wired_we got %0d want 15", random_out);
    end
    step(); step(); step();
    checks++;
    if (random_out !== 4'd12) begin
      errors++; $display("FAIL rnd_before_wr got %0d want 12", random_out);
    end
    do_op(2'b11, 4'd3, 32'hABCD_E077, 32'h2, 32'h3, "wr");
    checks++;
    if (entries[12].vpn2 !== 19'h55E6F || entries[12].asid !== 8'h77 ||
        entries[12].v0 !== 1'b1 || entries[12].v1 !== 1'b1 || entries[12].g !== 1'b0) begin
      errors++; $display("FAIL wr_entry12 got %h", entries[12]);
    end
    checks++;
    if (entries[11] !== ZERO_ENTRY || entries[13] !== ZERO_ENTRY || entries[3] !== ZERO_ENTRY) begin
      errors++; $display("FAIL wr_neighbours got %h %h %h want 0", entries[11], entries[13], entries[3]);
    end
  endtask

`ifdef TLB_FLUSH_EN
  task automatic test_flush();
    flush = 1'b1; op_valid = 1'b1; op = 2'b10; index_in = 4'd4;
    entryhi_in = 32'hFFFF_E000; entrylo0_in = 32'h2; entrylo1_in = 32'h2;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b want 0", op_ready);
    end
    step();
    flush = 1'b0; op_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (entries[i].v0 !== 1'b0 || entries[i].v1 !== 1'b0) begin
        errors++; $display("FAIL flush_v%0d got %b%b want 00", i, entries[i].v0, entries[i].v1);
      end
    end
    checks++;
    if (entries[12].vpn2 !== 19'h55E6F || entries[5].pfn0 !== 20'h00ABC) begin
      errors++; $display("FAIL flush_keep got %h %h", entries[12].vpn2, entries[5].pfn0);
    end
    step(); step();
    checks++;
    if (resp_valid !== 1'b0 || entries[4] !== ZERO_ENTRY || op_ready !== 1'b1) begin
      errors++; $display("FAIL flush_no_op got resp=%b e4=%h ready=%b", resp_valid, entries[4], op_ready);
    end
  endtask
`endif

  task automatic test_reset_abort();
    op = 2'b10; index_in = 4'd4; entryhi_in = 32'h5555_4033;
    entrylo0_in = 32'h3; entrylo1_in = 32'h3;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || resp_valid !== 1'b0 || random_out !== 4'd15) begin
      errors++;
      $display("FAIL abort_state got ready=%b resp=%b rnd=%0d want 1 0 15",
               op_ready, resp_valid, random_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resp_valid !== 1'b0 || entries[4] !== ZERO_ENTRY) begin
        errors++; $display("FAIL abort_cyc%0d got resp=%b e4=%h want 0 0", i, resp_valid, entries[4]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 2'b00; index_in = '0;
    entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0;
    wired_in = '0; wired_we = 1'b0;
`ifdef TLB_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_tlbwi();
    test_tlbp();
    test_tlbr();
    test_random_wired();
`ifdef TLB_FLUSH_EN
    test_flush();
`endif
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have clock port: clk  in  1  system clock, rising-edge active.
REQ-002 SHALL have reset port: rst  in  1  synchronous reset, active high.
REQ-003 SHALL have port: op_valid  in  1  TLB instruction request, held until accepted.
REQ-004 SHALL have port: op_ready  out  1  block idle and able to accept op.
REQ-005 SHALL have port: op  in  2  00=TLBP, 01=TLBR, 10=TLBWI, 11=TLBWR.
REQ-006 SHALL have port: index_in  in  4  CP0 Index[3:0] for TLBR/TLBWI.
REQ-007 SHALL have ports: entryhi_in, entrylo0_in, entrylo1_in  in  32 each  CP0 operand values.
REQ-008 SHALL have ports: wired_in  in  4  CP0 Wired; wired_we  in  1  Wired write strobe.
REQ-009 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: index_out  out  32  TLBP result: bit31=P (miss), [3:0]=matched index, rest 0.
REQ-011 SHALL have ports: entryhi_out, entrylo0_out, entrylo1_out  out  32 each  TLBR result.
REQ-012 SHALL have port: random_out  out  4  CP0 Random.
REQ-013 SHALL have port: entries  out  16 x tlb_entry_t  full TLB array, fed to the lookup units.

Function
REQ-014 SHALL use field maps: EntryHi VPN2=[31:13], ASID=[7:0]; EntryLo PFN=[25:6], C=[5:3], D=[2], V=[1], G=[0].
REQ-015 SHALL run FSM IDLE->BUSY->RESP->IDLE; op_ready=1 only in IDLE (and no flush that cycle).
REQ-016 SHALL accept an op on a clk edge with op_valid&op_ready, latching op, index_in, EntryHi/Lo operands and random_out into internal registers.
REQ-017 SHALL perform the action in BUSY; array writes take effect on the BUSY->RESP edge.
REQ-018 SHALL assert resp_valid for exactly the RESP cycle, i.e. 2 cycles after the accepting edge; TLB results are stable while resp_valid=1 and held until the next response.
REQ-019 SHALL, for TLBWI/TLBWR, write entry (index_in resp. latched Random): vpn2, asid from EntryHi; G = G(lo0) & G(lo1); pfn/c/d/v per page from lo0/lo1.
REQ-020 SHALL, for TLBP, compare latched EntryHi against all 16 entries (vpn2 equal and (asid equal or G)); on hit index_out = {1'b0, 27'b0, lowest matching index}; on miss index_out = 32'h8000_0000.
REQ-021 SHALL, for TLBR, return entry[index_in] with EntryHi = {vpn2, 5'b0, asid}, both EntryLo G bits = entry G, unused bits 0.
REQ-022 SHALL leave index_out unchanged on TLBR/TLBW*, and entry*_out unchanged on TLBP/TLBW*.
REQ-023 SHALL decrement Random every cycle; when Random <= wired_in, next value is 15.
REQ-024 SHALL set Random to 15 on any cycle with wired_we=1 (priority over decrement).
REQ-025 SHALL keep Random decrementing during BUSY/RESP; TLBWR uses the value latched at acceptance.
REQ-026 SHALL drive entries combinationally from the storage registers (no extra latency).

Reset
REQ-027 SHALL, on rst=1 at a clk edge: state=IDLE, Random=15, resp_valid=0, index_out=0, entry*_out=0, all 16 entries zero.
REQ-028 SHALL abort any in-flight op on rst without writing the array; op_ready=1 the cycle after rst deasserts.

Configuration
REQ-029 SHALL, with TLB_FLUSH_EN defined, add input flush  in  1; flush=1 in IDLE clears V0 and V1 of all entries at that edge, takes priority over op_valid, and op_ready=0 that cycle.
REQ-030 SHALL, without TLB_FLUSH_EN, omit the flush port and its logic; all other behaviour identical.

Verification
REQ-031 Reset, then 20 idle cycles with wired_in=3 -> random_out 15,14,...,3,15,14...; all entries zero.
REQ-032 TLBWI index_in=5, entryhi=32'h1234_A0_2A, lo0 PFN=0x00ABC V=1 G=1, lo1 G=0 -> resp_valid 2 cycles after accept, entries[5].vpn2=19'h091A5, asid=8'h2A, G=0.
REQ-033 TLBWI entries 2 and 9 with same VPN2, G=1; TLBP that VPN2, any ASID -> index_out=32'h0000_0002.
REQ-034 TLBP with unmatched VPN2 -> index_out=32'h8000_0000; TLBR index 5 -> entryhi_out=32'h1234_A02A, entrylo0_out G=0.
REQ-035 wired_we pulse while Random=7 -> random_out=15 next cycle; TLBWR accepted at Random=12 writes entry 12 only.
REQ-036 rst asserted in BUSY of TLBWI to index 4 -> entry 4 stays zero, no resp_valid; with TLB_FLUSH_EN, flush -> all V bits 0, vpn2 retained.
